statevector_gate_sequencer: RTL and testbench
=============================================

STATEVECTOR_GATE_SEQUENCER -- requirements
Module: statevector_gate_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_QUBITS, default 3, meaning the qubit count; NUM_STATES = 2**NUM_QUBITS and AW = $clog2(NUM_STATES).
REQ-002 The block SHALL have parameter AMPLITUDE_WIDTH, default 32, meaning the width of one real or imaginary component.
REQ-003 The block SHALL have one clock and a synchronous active-high reset; the reset is sampled on the rising edge of clk.
REQ-004 clk  in  1  system clock, all state on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  single-cycle request to apply one single-qubit gate pass.
REQ-007 target_qubit  in  $clog2(NUM_QUBITS)+1  target qubit index, captured when start is accepted.
REQ-008 busy, done, err  out  1 each  busy is pass in progress, done is 1-cycle completion pulse, err is set with done on an invalid target.
REQ-009 porta_en, porta_we  out  1 each  memory port A enable and write enable.
REQ-010 porta_addr  out  AW  memory port A address.
REQ-011 porta_din_re, porta_din_im  out  AMPLITUDE_WIDTH  memory port A write data.
REQ-012 porta_dout_re, porta_dout_im  in  AMPLITUDE_WIDTH  memory port A read data.
REQ-013 portb_en  out  1  memory port B read enable.
REQ-014 portb_addr  out  AW  memory port B read address.
REQ-015 portb_dout_re, portb_dout_im  in  AMPLITUDE_WIDTH  memory port B read data.
REQ-016 pair_valid, pair_ready  out/in  1  handshake that offers an amplitude pair to the gate unit.
REQ-017 amp0_re, amp0_im, amp1_re, amp1_im  out  AMPLITUDE_WIDTH  the |..0..> and |..1..> amplitudes of the current pair.
REQ-018 res_valid  in  1  gate unit result strobe, one cycle.
REQ-019 res0_re, res0_im, res1_re, res1_im  in  AMPLITUDE_WIDTH  updated amplitudes from the gate unit.

Function
REQ-020 The FSM states SHALL be IDLE, READ, WAIT, ISSUE, WAIT_RES, WRITE0, WRITE1, DONE.
REQ-021 In IDLE, start=1 SHALL capture target_qubit, clear pair counter k, and go to READ; if target_qubit>=NUM_QUBITS it SHALL go to DONE with err=1 and make no memory access.
REQ-022 The pair addresses SHALL be i0 = insertion of a 0 bit into k at position t, and i1 = i0 | (1<<t), for k = 0 .. NUM_STATES/2-1.
REQ-023 READ SHALL assert porta_en=1, porta_we=0, porta_addr=i0, portb_en=1, portb_addr=i1 for one cycle, then go to WAIT.
REQ-024 Memory read latency is one cycle; WAIT SHALL register both port outputs into amp0/amp1, then go to ISSUE.
REQ-025 ISSUE SHALL hold pair_valid=1 with stable amp outputs until pair_ready=1, then go to WAIT_RES; pair_valid SHALL be 0 in all other states.
REQ-026 WAIT_RES SHALL wait any number of cycles for res_valid, latch res0/res1, then go to WRITE0; res_valid in any other state SHALL be ignored.
REQ-027 WRITE0 SHALL write res0 to i0 via port A (en=1, we=1); WRITE1 SHALL write res1 to i1; port B SHALL be disabled in both.
REQ-028 After WRITE1, the block SHALL go to DONE if k = NUM_STATES/2-1, else increment k and go to READ.
REQ-029 DONE SHALL pulse done=1 for one cycle and return to IDLE; err SHALL hold its value until the next accepted start.
REQ-030 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored.
REQ-031 The minimum cost SHALL be 6 cycles per pair, so done occurs at the earliest 3*NUM_STATES+2 cycles after start.

Reset
REQ-032 On rst the block SHALL go to IDLE, clear k and err, and drive every output to 0.
REQ-033 A reset asserted mid-pass SHALL take effect on the next clock edge, and no memory write SHALL occur on the cycle in which rst is high.

Structure
REQ-034 Package qsim_pkg SHALL hold the amplitude typedef (re/im struct), the FSM state enum, and the pair-address function.
REQ-035 The i0/i1 generation SHALL be the sub-module statevector_pair_addr_gen (inputs k and t, outputs i0 and i1, combinational).

Verification
REQ-036 NUM_QUBITS=3, target 0, identity gate unit: port A/B address sequence SHALL be (0,1),(2,3),(4,5),(6,7); memory is unchanged; one done pulse; err=0.
REQ-037 Memory preloaded re=i*100, target 2, X (swap) gate unit: pairs SHALL be (0,4),(1,5),(2,6),(3,7), and after done addr0.re=400 and addr4.re=0.
REQ-038 pair_ready held low for 5 cycles, res_valid delayed 3 cycles: amp outputs SHALL stay stable, no write occurs early, and the final memory SHALL be correct.
REQ-039 target_qubit=3: done=1 and err=1 two cycles after start; porta_en and portb_en SHALL never assert.
REQ-040 rst asserted during WRITE0 of pair 2: no write to that address, outputs SHALL be 0 on the next cycle, and a new start SHALL run normally.
REQ-041 start re-pulsed while busy: ignored, exactly one done pulse, and the address sequence SHALL be uncorrupted.

Source files
------------

// File: rtl/statevector_gate_sequencer_pkg.sv
// Shared types for the state-vector gate sequencer: amplitude struct, FSM states,
// and the pair-address helper that splits the index space around the target bit.
package qsim_pkg;
  localparam int AMP_W   = 32;
  localparam int PAIR_AW = 16;

  typedef struct packed {
    logic [AMP_W-1:0] re;
    logic [AMP_W-1:0] im;
  } amp_t;

  typedef enum logic [2:0] {
    IDLE, READ, WAIT, ISSUE, WAIT_RES, WRITE0, WRITE1, DONE
  } seq_state_t;

  // Insert a 0 at bit position t of k: bits below t stay, bits at/above t move up one.
  function automatic logic [PAIR_AW-1:0] pair_i0(input logic [PAIR_AW-1:0] k,
                                                  input logic [3:0] t);
    logic [PAIR_AW-1:0] lo_mask;
    lo_mask = (PAIR_AW'(1) << t) - PAIR_AW'(1);
    return ((k & ~lo_mask) << 1) | (k & lo_mask);
  endfunction
endpackage

// File: rtl/statevector_gate_sequencer_if.sv
// Memory ports and gate-unit handshake between the sequencer (master) and its
// amplitude RAM / gate unit (slave).
interface statevector_gate_sequencer_if #(
  parameter int NUM_QUBITS      = 3,
  parameter int AMPLITUDE_WIDTH = 32
);
  localparam int AW = $clog2(2**NUM_QUBITS);

  logic                       porta_en, porta_we;
  logic [AW-1:0]              porta_addr;
  logic [AMPLITUDE_WIDTH-1:0] porta_din_re, porta_din_im;
  logic [AMPLITUDE_WIDTH-1:0] porta_dout_re, porta_dout_im;
  logic                       portb_en;
  logic [AW-1:0]              portb_addr;
  logic [AMPLITUDE_WIDTH-1:0] portb_dout_re, portb_dout_im;
  logic                       pair_valid, pair_ready;
  logic [AMPLITUDE_WIDTH-1:0] amp0_re, amp0_im, amp1_re, amp1_im;
  logic                       res_valid;
  logic [AMPLITUDE_WIDTH-1:0] res0_re, res0_im, res1_re, res1_im;

  modport master (
    output porta_en, porta_we, porta_addr, porta_din_re, porta_din_im,
    input  porta_dout_re, porta_dout_im,
    output portb_en, portb_addr,
    input  portb_dout_re, portb_dout_im,
    output pair_valid, amp0_re, amp0_im, amp1_re, amp1_im,
    input  pair_ready,
    input  res_valid, res0_re, res0_im, res1_re, res1_im
  );

  modport slave (
    input  porta_en, porta_we, porta_addr, porta_din_re, porta_din_im,
    output porta_dout_re, porta_dout_im,
    input  portb_en, portb_addr,
    output portb_dout_re, portb_dout_im,
    input  pair_valid, amp0_re, amp0_im, amp1_re, amp1_im,
    output pair_ready,
    output res_valid, res0_re, res0_im, res1_re, res1_im
  );
endinterface

// File: rtl/statevector_pair_addr_gen.sv
// Combinational pair addresses for pair index k on target qubit t.
module statevector_pair_addr_gen
  import qsim_pkg::*;
#(
  parameter int AW = 3,
  parameter int TW = 2
) (
  input  logic [AW-1:0] k,
  input  logic [TW-1:0] t,
  output logic [AW-1:0] i0,
  output logic [AW-1:0] i1
);
  logic [PAIR_AW-1:0] i0_full;
  logic               unused_hi;

  assign i0_full   = pair_i0(PAIR_AW'(k), 4'(t));
  assign unused_hi = ^i0_full[PAIR_AW-1:AW];
  assign i0        = i0_full[AW-1:0];
  assign i1        = i0 | (AW'(1) << t);
endmodule

// File: rtl/statevector_gate_sequencer.sv
// Walks every amplitude pair of one target qubit: read both, hand to the gate unit,
// write the results back, then pulse done.
module statevector_gate_sequencer
  import qsim_pkg::*;
#(
  parameter int NUM_QUBITS      = 3,
  parameter int AMPLITUDE_WIDTH = 32,
  localparam int NUM_STATES     = 2**NUM_QUBITS,
  localparam int AW             = $clog2(NUM_STATES),
  localparam int TW             = $clog2(NUM_QUBITS) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [TW-1:0] target_qubit,
  output logic          busy,
  output logic          done,
  output logic          err,
  statevector_gate_sequencer_if.master sv
);
  typedef struct packed {
    logic [AMPLITUDE_WIDTH-1:0] re;
    logic [AMPLITUDE_WIDTH-1:0] im;
  } amp_w_t;

  localparam logic [AW-1:0] K_LAST = AW'(NUM_STATES/2 - 1);

  seq_state_t    state, nxt;
  logic [AW-1:0] k, i0, i1;
  logic [TW-1:0] t;
  amp_w_t        amp0, amp1, res0, res1;
  logic          tgt_bad;

  assign tgt_bad = (target_qubit >= TW'(NUM_QUBITS));

  statevector_pair_addr_gen #(.AW(AW), .TW(TW)) u_addr (
    .k(k), .t(t), .i0(i0), .i1(i1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      t     <= '0;
      err   <= 1'b0;
      amp0  <= '0;
      amp1  <= '0;
      res0  <= '0;
      res1  <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (start) begin
          t   <= target_qubit;
          k   <= '0;
          err <= tgt_bad;
        end
        WAIT: begin
          amp0 <= '{re: sv.porta_dout_re, im: sv.porta_dout_im};
          amp1 <= '{re: sv.portb_dout_re, im: sv.portb_dout_im};
        end
        WAIT_RES: if (sv.res_valid) begin
          res0 <= '{re: sv.res0_re, im: sv.res0_im};
          res1 <= '{re: sv.res1_re, im: sv.res1_im};
        end
        WRITE1: if (k != K_LAST) k <= k + 1'b1;
        default: ;
      endcase
    end
  end

  // Every strobe is qualified by !rst so a reset cycle can never write memory.
  always_comb begin
    nxt             = state;
    busy            = 1'b0;
    done            = 1'b0;
    sv.porta_en     = 1'b0;
    sv.porta_we     = 1'b0;
    sv.porta_addr   = '0;
    sv.porta_din_re = '0;
    sv.porta_din_im = '0;
    sv.portb_en     = 1'b0;
    sv.portb_addr   = '0;
    sv.pair_valid   = 1'b0;
    if (!rst) begin
      busy = (state != IDLE);
      case (state)
        IDLE:     if (start) nxt = tgt_bad ? DONE : READ;
        READ: begin
          sv.porta_en   = 1'b1;
          sv.porta_addr = i0;
          sv.portb_en   = 1'b1;
          sv.portb_addr = i1;
          nxt           = WAIT;
        end
        WAIT:     nxt = ISSUE;
        ISSUE: begin
          sv.pair_valid = 1'b1;
          if (sv.pair_ready) nxt = WAIT_RES;
        end
        WAIT_RES: if (sv.res_valid) nxt = WRITE0;
        WRITE0: begin
          sv.porta_en     = 1'b1;
          sv.porta_we     = 1'b1;
          sv.porta_addr   = i0;
          sv.porta_din_re = res0.re;
          sv.porta_din_im = res0.im;
          nxt             = WRITE1;
        end
        WRITE1: begin
          sv.porta_en     = 1'b1;
          sv.porta_we     = 1'b1;
          sv.porta_addr   = i1;
          sv.porta_din_re = res1.re;
          sv.porta_din_im = res1.im;
          nxt             = (k == K_LAST) ? DONE : READ;
        end
        DONE: begin
          done = 1'b1;
          nxt  = IDLE;
        end
        default:  nxt = IDLE;
      endcase
    end
  end

  assign sv.amp0_re = amp0.re;
  assign sv.amp0_im = amp0.im;
  assign sv.amp1_re = amp1.re;
  assign sv.amp1_im = amp1.im;
endmodule

// File: tb/tb_statevector_gate_sequencer.sv
// Bench: behavioural RAM and gate unit around the sequencer, directed plus random passes
// checked against a pair-index / gate model.
module tb_statevector_gate_sequencer;
  import qsim_pkg::*;

  localparam int NQ = 3;
  localparam int NS = 1 << NQ;
  localparam int AW = $clog2(NS);
  localparam int TW = $clog2(NQ) + 1;
  localparam int W  = 32;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [TW-1:0] target_qubit;
  logic          busy, done, err;

  always #5 clk = ~clk;

  statevector_gate_sequencer_if #(.NUM_QUBITS(NQ), .AMPLITUDE_WIDTH(W)) sv ();

  statevector_gate_sequencer #(.NUM_QUBITS(NQ), .AMPLITUDE_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .target_qubit(target_qubit),
    .busy(busy), .done(done), .err(err), .sv(sv)
  );

  typedef struct { int a; int b; bit ben; } rd_t;
  typedef struct { int addr; amp_t d; } wr_t;
  typedef struct { amp_t a0; amp_t a1; } hs_t;

  amp_t mem [NS];
  amp_t load_img [NS];
  amp_t snap [NS];
  bit   load_req = 1'b0;
  rd_t  rd_q [$];
  wr_t  wr_q [$];
  hs_t  hs_q [$];
  int   done_cnt = 0, en_cnt = 0, unstable = 0, bwr_cnt = 0;
  int   gate_sel = 0, rdy_dly = 0, res_dly = 0;
  bit   noise_en = 1'b0;
  int   total = 0, bad = 0;
  int   rb, wb, hb, db, eb, ub, bb;

  // Gate unit behaviour: 0 identity, 1 swap (X), 2 unscaled sum/difference.
  function automatic void gate_fn(input int g, input amp_t a0, input amp_t a1,
                                  output amp_t r0, output amp_t r1);
    case (g)
      0:       begin r0 = a0; r1 = a1; end
      1:       begin r0 = a1; r1 = a0; end
      default: begin
        r0.re = a0.re + a1.re; r0.im = a0.im + a1.im;
        r1.re = a0.re - a1.re; r1.im = a0.im - a1.im;
      end
    endcase
  endfunction

  function automatic int exp_i0(input int k, input int t);
    return (k / (1 << t)) * (1 << (t + 1)) + k % (1 << t);
  endfunction

  // Amplitude RAM: one-cycle read latency on both ports, writes on port A.
  always @(posedge clk) begin
    if (load_req) for (int i = 0; i < NS; i++) mem[i] = load_img[i];
    if (sv.porta_en && sv.porta_we) mem[sv.porta_addr] = '{re: sv.porta_din_re, im: sv.porta_din_im};
    if (sv.porta_en && !sv.porta_we) begin
      sv.porta_dout_re <= mem[sv.porta_addr].re;
      sv.porta_dout_im <= mem[sv.porta_addr].im;
    end
    if (sv.portb_en) begin
      sv.portb_dout_re <= mem[sv.portb_addr].re;
      sv.portb_dout_im <= mem[sv.portb_addr].im;
    end
  end

  int rdy_cnt = 0;
  always @(negedge clk) begin
    if (sv.pair_valid) begin
      if (rdy_cnt >= rdy_dly) sv.pair_ready = 1'b1;
      else begin sv.pair_ready = 1'b0; rdy_cnt++; end
    end else begin
      sv.pair_ready = 1'b0;
      rdy_cnt = 0;
    end
  end

  int   gu_cnt = 0;
  amp_t gu_r0, gu_r1;
  always @(posedge clk) begin : gate_unit
    logic v;
    amp_t o0, o1;
    v = 1'b0; o0 = gu_r0; o1 = gu_r1;
    if (sv.pair_valid && sv.pair_ready) begin
      hs_q.push_back('{a0: '{re: sv.amp0_re, im: sv.amp0_im}, a1: '{re: sv.amp1_re, im: sv.amp1_im}});
      gate_fn(gate_sel, '{re: sv.amp0_re, im: sv.amp0_im}, '{re: sv.amp1_re, im: sv.amp1_im}, gu_r0, gu_r1);
      o0 = gu_r0; o1 = gu_r1;
      if (res_dly == 0) v = 1'b1; else gu_cnt = res_dly;
    end else if (gu_cnt > 0) begin
      gu_cnt--;
      v = (gu_cnt == 0);
    end else if (noise_en && $urandom_range(3) == 0) begin
      v = 1'b1;
      o0 = {$urandom, $urandom};
      o1 = {$urandom, $urandom};
    end
    sv.res_valid <= v;
    sv.res0_re <= o0.re; sv.res0_im <= o0.im;
    sv.res1_re <= o1.re; sv.res1_im <= o1.im;
  end

  logic pv_prev = 1'b0;
  amp_t p0, p1;
  always @(negedge clk) begin
    if (sv.porta_en && !sv.porta_we) rd_q.push_back('{a: int'(sv.porta_addr), b: int'(sv.portb_addr), ben: sv.portb_en});
    if (sv.porta_en && sv.porta_we) begin
      wr_q.push_back('{addr: int'(sv.porta_addr), d: '{re: sv.porta_din_re, im: sv.porta_din_im}});
      if (sv.portb_en) bwr_cnt++;
    end
    if (sv.porta_en || sv.portb_en) en_cnt++;
    if (done) done_cnt++;
    if (sv.pair_valid && pv_prev && (p0 != {sv.amp0_re, sv.amp0_im} || p1 != {sv.amp1_re, sv.amp1_im})) unstable++;
    pv_prev = sv.pair_valid;
    p0 = {sv.amp0_re, sv.amp0_im};
    p1 = {sv.amp1_re, sv.amp1_im};
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  // mode 0: random with distinct re low bits; mode 1: re = index*100.
  task automatic load_mem(input int mode);
    for (int i = 0; i < NS; i++) begin
      load_img[i].re = (mode == 1) ? 32'(i * 100) : (($urandom & ~32'h7) | 32'(i));
      load_img[i].im = $urandom;
    end
    load_req = 1'b1;
    tick;
    load_req = 1'b0;
  endtask

  task automatic take_snap;
    for (int i = 0; i < NS; i++) snap[i] = mem[i];
    rb = rd_q.size(); wb = wr_q.size(); hb = hs_q.size();
    db = done_cnt; eb = en_cnt; ub = unstable; bb = bwr_cnt;
  endtask

  // lat counts cycles inclusively, from the cycle start is high to the done cycle.
  task automatic run_pass(input int tgt, input int g, input int rd, input int sd,
                          input bit repulse, output int lat);
    int cyc;
    take_snap();
    gate_sel = g; rdy_dly = rd; res_dly = sd;
    target_qubit = TW'(tgt);
    start = 1'b1;
    cyc = 1; lat = 0;
    while (lat == 0 && cyc < 2000) begin
      tick; cyc++;
      if (cyc == 2) start = 1'b0;
      if (repulse && cyc == 9) begin start = 1'b1; target_qubit = TW'((tgt + 1) % NQ); end
      if (repulse && cyc == 10) start = 1'b0;
      if (done) lat = cyc;
    end
    chk("done_seen", 64'(lat != 0), 64'(1));
    repeat (3) tick;
  endtask

  task automatic check_pass(input int tgt, input int g, input int lat, input bit exact);
    amp_t ex [NS];
    amp_t r0, r1;
    int   i0, i1;
    if (exact) chk("latency", 64'(lat), 64'(3 * NS + 2));
    else       chk("latency_min", 64'(lat >= 3 * NS + 2), 64'(1));
    chk("done_pulses", 64'(done_cnt - db), 64'(1));
    chk("err_clear", 64'(err), 64'(0));
    chk("busy_after", 64'(busy), 64'(0));
    chk("n_reads", 64'(rd_q.size() - rb), 64'(NS / 2));
    chk("n_writes", 64'(wr_q.size() - wb), 64'(NS));
    chk("n_handshakes", 64'(hs_q.size() - hb), 64'(NS / 2));
    chk("amp_stable", 64'(unstable - ub), 64'(0));
    chk("portb_off_on_write", 64'(bwr_cnt - bb), 64'(0));
    for (int i = 0; i < NS; i++) ex[i] = snap[i];
    for (int k = 0; k < NS / 2; k++) begin
      i0 = exp_i0(k, tgt);
      i1 = i0 + (1 << tgt);
      gate_fn(g, snap[i0], snap[i1], r0, r1);
      ex[i0] = r0; ex[i1] = r1;
      if (rb + k < rd_q.size()) begin
        chk($sformatf("pair%0d_a", k), 64'(rd_q[rb + k].a), 64'(i0));
        chk($sformatf("pair%0d_b", k), 64'(rd_q[rb + k].b), 64'(i1));
        chk($sformatf("pair%0d_ben", k), 64'(rd_q[rb + k].ben), 64'(1));
      end
      if (hb + k < hs_q.size()) begin
        chk($sformatf("amp0_k%0d", k), hs_q[hb + k].a0, snap[i0]);
        chk($sformatf("amp1_k%0d", k), hs_q[hb + k].a1, snap[i1]);
      end
      if (wb + 2 * k + 1 < wr_q.size()) begin
        chk($sformatf("w0_addr_k%0d", k), 64'(wr_q[wb + 2 * k].addr), 64'(i0));
        chk($sformatf("w0_data_k%0d", k), wr_q[wb + 2 * k].d, r0);
        chk($sformatf("w1_addr_k%0d", k), 64'(wr_q[wb + 2 * k + 1].addr), 64'(i1));
        chk($sformatf("w1_data_k%0d", k), wr_q[wb + 2 * k + 1].d, r1);
      end
    end
    for (int i = 0; i < NS; i++) chk($sformatf("mem%0d", i), mem[i], ex[i]);
  endtask

  initial begin
    int lat, cyc, tg, g, rd, sd;
    bit hit, err_at_done;

    rst = 1'b1; start = 1'b0; target_qubit = '0;
    repeat (3) tick;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_porta_en", 64'(sv.porta_en), 64'(0));
    chk("rst_portb_en", 64'(sv.portb_en), 64'(0));
    chk("rst_pair_valid", 64'(sv.pair_valid), 64'(0));
    chk("rst_amps", {sv.amp0_re, sv.amp1_im}, 64'(0));
    rst = 1'b0;
    tick;
    chk("idle_busy", 64'(busy), 64'(0));

    // identity on qubit 0, minimum timing
    load_mem(0);
    run_pass(0, 0, 0, 0, 1'b0, lat);
    check_pass(0, 0, lat, 1'b1);

    // swap on qubit 2 with re = index*100
    load_mem(1);
    run_pass(2, 1, 0, 0, 1'b0, lat);
    check_pass(2, 1, lat, 1'b1);
    chk("x_addr0_re", 64'(mem[0].re), 64'(400));
    chk("x_addr4_re", 64'(mem[4].re), 64'(0));

    // back-pressure on the pair handshake and slow results, with stray res_valid
    noise_en = 1'b1;
    load_mem(0);
    run_pass(1, 2, 5, 3, 1'b0, lat);
    check_pass(1, 2, lat, 1'b0);

    // invalid target: immediate done with err, no memory traffic
    take_snap();
    target_qubit = TW'(3); start = 1'b1;
    cyc = 1; lat = 0; err_at_done = 1'b0;
    while (lat == 0 && cyc < 20) begin
      tick; cyc++;
      start = 1'b0;
      if (done) begin lat = cyc; err_at_done = err; end
    end
    chk("bad_tgt_latency", 64'(lat), 64'(2));
    chk("bad_tgt_err", 64'(err_at_done), 64'(1));
    repeat (3) tick;
    chk("bad_tgt_err_hold", 64'(err), 64'(1));
    chk("bad_tgt_no_mem", 64'(en_cnt - eb), 64'(0));
    chk("bad_tgt_done_pulses", 64'(done_cnt - db), 64'(1));

    // reset during WRITE0 of pair 2 (target 1 => address 4)
    load_mem(0);
    take_snap();
    gate_sel = 1; rdy_dly = 0; res_dly = 0;
    target_qubit = TW'(1); start = 1'b1;
    cyc = 0; hit = 1'b0;
    while (!hit && cyc < 200) begin
      tick; cyc++;
      start = 1'b0;
      if (sv.porta_we && sv.porta_addr == AW'(exp_i0(2, 1)) && wr_q.size() - wb == 5) hit = 1'b1;
    end
    chk("rst_hit_write0", 64'(hit), 64'(1));
    rst = 1'b1;
    #1;
    chk("rst_gates_we", 64'(sv.porta_en), 64'(0));
    tick;
    chk("rst_nowrite", mem[exp_i0(2, 1)], snap[exp_i0(2, 1)]);
    chk("rst2_busy", 64'(busy), 64'(0));
    chk("rst2_done", 64'(done), 64'(0));
    chk("rst2_porta_en", 64'(sv.porta_en), 64'(0));
    chk("rst2_pair_valid", 64'(sv.pair_valid), 64'(0));
    chk("rst2_amps", {sv.amp0_re, sv.amp0_im}, 64'(0));
    rst = 1'b0;
    tick;
    load_mem(0);
    run_pass(1, 1, 0, 0, 1'b0, lat);
    check_pass(1, 1, lat, 1'b1);

    // start re-pulsed mid-pass with a different target
    load_mem(0);
    run_pass(1, 2, 0, 0, 1'b1, lat);
    check_pass(1, 2, lat, 1'b1);

    // random passes
    for (int n = 0; n < 5; n++) begin
      tg = $urandom_range(NQ - 1);
      g  = $urandom_range(2);
      rd = $urandom_range(3);
      sd = $urandom_range(3);
      load_mem(0);
      run_pass(tg, g, rd, sd, 1'b0, lat);
      check_pass(tg, g, lat, (rd == 0 && sd == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
